// File: rtl/gauss_frame_ctrl.sv
// gauss_frame_ctrl: frame/raster controller for a 5x5 Gaussian window, emits interior pixel strobes.
// Optional sticky protocol-error output err when GAUSS_FRAME_CTRL_ERR_EN is defined.
module gauss_frame_ctrl #(
  parameter int WIDTH    = 512,
  parameter int HEIGHT   = 512,
  parameter int R_KERNEL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       in_ready,
  output logic       buf_write,
  output logic [7:0] buf_pixel,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       busy,
  output logic       done
`ifdef GAUSS_FRAME_CTRL_ERR_EN
  , output logic     err
`endif
);
  localparam int NOUT = (WIDTH - 2*R_KERNEL) * (HEIGHT - 2*R_KERNEL);
  localparam int CW   = $clog2(NOUT + 1);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state;
  logic [XW-1:0]   in_col;
  logic [YW-1:0]   in_row;
  logic [CW-1:0]   out_cnt;
  logic            accept, col_end, row_end, emit;
  assign in_ready  = state == RUN;
  assign busy      = state != IDLE;
  assign accept    = in_valid & in_ready;
  assign buf_write = accept;
  assign buf_pixel = in_pixel;
  assign col_end   = in_col == XW'(WIDTH - 1);
  assign row_end   = in_row == YW'(HEIGHT - 1);
  // an abort in the same cycle suppresses the output strobe of that pixel
  assign emit      = accept & ~abort & (in_col >= XW'(2*R_KERNEL)) & (in_row >= YW'(2*R_KERNEL));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_col    <= '0;
      in_row    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && out_cnt == '0;
      out_eol   <= emit & col_end;
      out_eof   <= emit && out_cnt == CW'(NOUT - 1);
      done      <= state == DONE;
      if (emit) out_cnt <= out_cnt + 1'b1;
      if (accept) begin
        in_col <= col_end ? '0 : in_col + 1'b1;
        if (col_end) in_row <= in_row + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          in_col  <= '0;
          in_row  <= '0;
          out_cnt <= '0;
        end
        RUN: if (abort) state <= IDLE;
             else if (accept & col_end & row_end) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef GAUSS_FRAME_CTRL_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (start && state == IDLE) err <= 1'b0;
    else if ((start && state != IDLE) || (in_valid && state == IDLE)) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// tb_gauss_frame_ctrl: vector table, directed frame sequences and random traffic against a pixel-count model.
module tb_gauss_frame_ctrl;
  localparam int W = 8, H = 8, R = 2;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0;
  logic [7:0] in_pixel = 0;
  logic in_ready, buf_write, out_valid, out_sof, out_eol, out_eof, busy, done;
  logic [7:0] buf_pixel;
`ifdef GAUSS_FRAME_CTRL_ERR_EN
  logic err;
`endif
  gauss_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .R_KERNEL(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_ready(in_ready), .buf_write(buf_write), .buf_pixel(buf_pixel),
    .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .done(done)
`ifdef GAUSS_FRAME_CTRL_ERR_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit m_run = 0;
  int m_n = 0, m_since = 99;
  int cyc_no = 0, n_ov, n_eol, sof_first, eof_cyc, done_cyc, ov16_cyc, done_seen;
  typedef struct {bit s, a, v; logic [7:0] p; bit e_rdy, e_busy, e_ov, e_done, e_err;} vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic clr_track();
    n_ov = 0; n_eol = 0; sof_first = 0; eof_cyc = -1; done_cyc = -1; ov16_cyc = -1; done_seen = 0;
  endtask
  task automatic cyc(input bit s, input bit a, input bit v, input logic [7:0] p);
    bit acc, idle, eov, esof, eeol, eeof;
    int c, r;
    start = s; abort = a; in_valid = v; in_pixel = p;
    #1;
    chk("in_ready", in_ready, m_run);
    chk("buf_write", buf_write, v & m_run);
    chk("buf_pixel", buf_pixel, p);
    acc  = v && m_run;
    idle = !m_run && m_since != 0;
    c = m_n % W; r = m_n / W;
    eov  = acc && !a && c >= 2*R && r >= 2*R;
    esof = eov && c == 2*R && r == 2*R;
    eeol = eov && c == W-1;
    eeof = eov && m_n == W*H-1;
    if (m_since < 99) m_since++;
    if (m_run) begin
      if (a) m_run = 0;
      else if (acc) begin
        m_n++;
        if (m_n == W*H) begin m_run = 0; m_since = 0; end
      end
    end else if (s && idle) begin
      m_run = 1; m_n = 0;
    end
    @(posedge clk); #1;
    cyc_no++;
    chk("out_valid", out_valid, eov);
    chk("out_sof", out_sof, esof);
    chk("out_eol", out_eol, eeol);
    chk("out_eof", out_eof, eeof);
    chk("busy", busy, m_run || m_since == 0);
    chk("done", done, m_since == 1);
    if (out_valid) begin
      n_ov++;
      if (n_ov == 16) ov16_cyc = cyc_no;
      if (out_sof && n_ov == 1) sof_first = 1;
      if (out_eol) n_eol++;
      if (out_eof) eof_cyc = cyc_no;
    end
    if (done) begin done_cyc = cyc_no; done_seen++; end
  endtask
  task automatic frame_checks(input string tag);
    chk({tag, "_ov_count"}, n_ov, 16);
    chk({tag, "_eol_count"}, n_eol, 4);
    chk({tag, "_sof_first"}, sof_first, 1);
    chk({tag, "_eof_is_16th"}, eof_cyc, ov16_cyc);
    chk({tag, "_done_after_eof"}, done_cyc, eof_cyc + 1);
  endtask
  initial begin
    tbl[0] = '{0, 0, 1, 8'h11, 0, 0, 0, 0, 1};
    tbl[1] = '{1, 0, 0, 8'h00, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 8'h22, 1, 1, 0, 0, 1};
    tbl[3] = '{0, 0, 1, 8'h33, 1, 1, 0, 0, 1};
    tbl[4] = '{0, 1, 1, 8'h44, 0, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 1, 8'h55, 0, 0, 0, 0, 1};
    in_valid = 1;
    #3;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_buf_write", buf_write, 0);
    #9 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].p);
      chk("tbl_ready", in_ready, tbl[i].e_rdy);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      chk("tbl_done", done, tbl[i].e_done);
`ifdef GAUSS_FRAME_CTRL_ERR_EN
      chk("tbl_err", err, tbl[i].e_err);
`endif
    end
    clr_track();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 8'(i));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    frame_checks("held");
    clr_track();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 128; i++) cyc(0, 0, ~i[0], 8'(i));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    frame_checks("toggle");
    clr_track();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 8'(i));
    cyc(0, 1, 1, 8'hAA);
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(i));
    chk("abort_no_done", done_seen, 0);
    clr_track();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 8'(i));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    frame_checks("after_abort");
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'(i));
    in_valid = 1; start = 0; abort = 0;
    #3 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_buf_write", buf_write, 0);
    chk("arst_eol", out_eol, 0);
    chk("arst_done", done, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    m_run = 0; m_since = 99;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'(i));
    clr_track();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 8'(i));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    frame_checks("after_reset");
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 3) != 0, 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
